snn_mac_arbiter: RTL and testbench

Two-requester round-robin arbiter and 3-stage pipeline for the shared 9-lane MAC engine of the SNN feature path. Image-1 and image-2 extraction pipes each submit a 3x3 window plus operands. The engine multiplies, reduces and quantizes each job, and returns a tagged result. One job is granted per cycle. Jobs are either CONV (9 lanes, quantize by 2295) or FC (lanes 0-1, quantize by 510).

---
 rtl/snn_mac_arbiter_if.sv | 33 +++
 rtl/snn_mac_arbiter.sv | 108 ++++++++++
 tb/tb_snn_mac_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_mac_arbiter_if.sv
// snn_mac_arbiter_if
//   Request/grant and response bundle for the shared 9-lane MAC engine.
//   master : requester/consumer side (drives stall, req*, mode*, pix*, coef*)
//   slave  : engine side (drives gnt*, rsp_*, busy)
//   pix*/coef* pack nine 8-bit unsigned lanes; lane k is bits [8k+7:8k].
interface snn_mac_arbiter_if;
  logic        stall;
  logic        req0;
  logic        req1;
  logic        mode0;
  logic        mode1;
  logic [71:0] pix0;
  logic [71:0] pix1;
  logic [71:0] coef0;
  logic [71:0] coef1;
  logic        gnt0;
  logic        gnt1;
  logic        rsp_valid;
  logic        rsp_id;
  logic [19:0] rsp_raw;
  logic [7:0]  rsp_q;
  logic        busy;

  modport master (
    output stall, req0, req1, mode0, mode1, pix0, pix1, coef0, coef1,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_raw, rsp_q, busy
  );

  modport slave (
    input  stall, req0, req1, mode0, mode1, pix0, pix1, coef0, coef1,
    output gnt0, gnt1, rsp_valid, rsp_id, rsp_raw, rsp_q, busy
  );
endinterface

// File: rtl/snn_mac_arbiter.sv
// snn_mac_arbiter
//   Two-requester round-robin arbiter in front of a 3-stage MAC pipeline.
//   S1 captures the granted job, S2 holds the nine lane products, S3 is the
//   output register carrying the reduced sum and its quantized value.
//   CONV jobs use all nine lanes and quantize by 2295; FC jobs use lanes 0-1
//   and quantize by 510.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous, ACTIVE-HIGH reset (name kept for compatibility)
//   bus   : snn_mac_arbiter_if.slave (stall, requests, grants, response, busy)
module snn_mac_arbiter (
  input  logic                   clk,
  input  logic                   rst_n,
  snn_mac_arbiter_if.slave       bus
);

  logic        last;      // requester granted most recently
  logic        winner;
  logic        hs;
  logic        hs_id;

  logic        v1;
  logic        v2;

  logic        s1_id;
  logic        s1_mode;
  logic [71:0] s1_pix;
  logic [71:0] s1_coef;

  logic        s2_id;
  logic        s2_mode;
  logic [15:0] s2_prod [9];

  logic [15:0] prod_next [9];
  logic [19:0] raw_sum;
  logic [7:0]  q_next;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    if (bus.req0 && bus.req1) winner = ~last;
    else                      winner = bus.req1;
  end

  assign bus.gnt0 = bus.req0 & ~bus.stall & ~rst_n & ~winner;
  assign bus.gnt1 = bus.req1 & ~bus.stall & ~rst_n &  winner;
  assign hs       = bus.gnt0 | bus.gnt1;
  assign hs_id    = bus.gnt1;

  // FC jobs only use lanes 0-1; the rest are forced to zero.
  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      if (s1_mode && k >= 2) prod_next[k] = '0;
      else prod_next[k] = 16'(s1_pix[8*k +: 8]) * 16'(s1_coef[8*k +: 8]);
    end
  end

  always_comb begin
    raw_sum = '0;
    for (int unsigned k = 0; k < 9; k++) raw_sum = raw_sum + 20'(s2_prod[k]);
  end

  // Both quotients are bounded by 255 for any legal operand set.
  assign q_next = s2_mode ? 8'(raw_sum / 20'd510) : 8'(raw_sum / 20'd2295);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      last          <= 1'b1;
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_raw   <= '0;
      bus.rsp_q     <= '0;
    end else begin
      if (hs) last <= hs_id;
      // Under stall S1/S2 freeze and S3 takes a bubble; the held S2 job is
      // released exactly once on the first unstalled edge.
      if (!bus.stall) begin
        v1 <= hs;
        v2 <= v1;
      end
      bus.rsp_valid <= v2 & ~bus.stall;
      if (v2 && !bus.stall) begin
        bus.rsp_id  <= s2_id;
        bus.rsp_raw <= raw_sum;
        bus.rsp_q   <= q_next;
      end
    end
  end

  // Payload registers: qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (hs) begin
      s1_id   <= hs_id;
      s1_mode <= hs_id ? bus.mode1 : bus.mode0;
      s1_pix  <= hs_id ? bus.pix1  : bus.pix0;
      s1_coef <= hs_id ? bus.coef1 : bus.coef0;
    end
    if (!bus.stall) begin
      s2_id   <= s1_id;
      s2_mode <= s1_mode;
      s2_prod <= prod_next;
    end
  end

  assign bus.busy = v1 | v2 | bus.rsp_valid;

endmodule

// File: tb/tb_snn_mac_arbiter.sv
// tb_snn_mac_arbiter
//   Directed bench for snn_mac_arbiter: reset values, round-robin tie,
//   single CONV/FC jobs, stall, back-to-back quantizer boundaries and
//   reset while a job is in flight.
module tb_snn_mac_arbiter;
  logic        clk;
  logic        rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  snn_mac_arbiter_if bus();

  snn_mac_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.stall = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.mode0 = 1'b0;
    bus.mode1 = 1'b0;
    bus.pix0  = '0;
    bus.pix1  = '0;
    bus.coef0 = '0;
    bus.coef1 = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    idle_inputs();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_gnt: got %b want 00", {bus.gnt0, bus.gnt1});
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q, bus.busy} !== 31'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q, bus.busy});
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n    = 1'b0;
    tick();
    n_cmp++;
    if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release_idle: got %b want 00", {bus.busy, bus.rsp_valid});
    end
  endtask

  // Both requesters held for four cycles straight out of reset.
  task automatic test_tie;
    logic [1:0]  exp_g;
    logic        exp_id;
    logic [19:0] exp_raw;
    bus.pix0  = 72'd1;
    bus.coef0 = 72'd10;
    bus.pix1  = 72'd2;
    bus.coef1 = 72'd10;
    for (int i = 0; i < 8; i++) begin
      bus.req0 = (i < 4);
      bus.req1 = (i < 4);
      #1;
      exp_g = (i < 4) ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++;
      if ({bus.gnt0, bus.gnt1} !== exp_g) begin
        n_err++;
        $display("FAIL tie_gnt[%0d]: got %b want %b", i, {bus.gnt0, bus.gnt1}, exp_g);
      end
      if (i >= 3 && i <= 6) begin
        exp_id  = ((i - 3) % 2 == 1);
        exp_raw = exp_id ? 20'd20 : 20'd10;
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q} !== {1'b1, exp_id, exp_raw, 8'd0}) begin
          n_err++;
          $display("FAIL tie_rsp[%0d]: got v=%b id=%b raw=%0d q=%0d want v=1 id=%b raw=%0d q=0",
                   i, bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q, exp_id, exp_raw);
        end
      end else begin
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL tie_idle[%0d]: got rsp_valid=%b want 0", i, bus.rsp_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_conv_single;
    bus.req0  = 1'b1;
    bus.mode0 = 1'b0;
    bus.pix0  = '1;
    bus.coef0 = '1;
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_err++;
      $display("FAIL conv_gnt: got %b want 10", {bus.gnt0, bus.gnt1});
    end
    tick();
    bus.req0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c == 3) begin
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q, bus.busy} !== {1'b1, 1'b0, 20'd585225, 8'd255, 1'b1}) begin
          n_err++;
          $display("FAIL conv_rsp: got v=%b id=%b raw=%0d q=%0d busy=%b want v=1 id=0 raw=585225 q=255 busy=1",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q, bus.busy);
        end
      end else begin
        n_cmp++;
        if ({bus.rsp_valid, bus.busy} !== {1'b0, (c < 4)}) begin
          n_err++;
          $display("FAIL conv_cycle[%0d]: got v=%b busy=%b want v=0 busy=%b",
                   c, bus.rsp_valid, bus.busy, (c < 4));
        end
      end
      tick();
    end
  endtask

  task automatic test_fc;
    bus.req1  = 1'b1;
    bus.mode1 = 1'b1;
    bus.pix1  = {{7{8'hFF}}, 8'd100, 8'd200};
    bus.coef1 = {{7{8'hFF}}, 8'd4, 8'd3};
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      n_err++;
      $display("FAIL fc_gnt: got %b want 01", {bus.gnt0, bus.gnt1});
    end
    tick();
    bus.req1 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q} !== {1'b1, 1'b1, 20'd1000, 8'd1}) begin
      n_err++;
      $display("FAIL fc_rsp: got v=%b id=%b raw=%0d q=%0d want v=1 id=1 raw=1000 q=1",
               bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q);
    end
    tick();
  endtask

  task automatic test_stall;
    int pulses = 0;
    bus.req0  = 1'b1;
    bus.mode0 = 1'b0;
    bus.pix0  = {9{8'd100}};
    bus.coef0 = {9{8'd50}};
    #1;
    n_cmp++;
    if (bus.gnt0 !== 1'b1) begin
      n_err++;
      $display("FAIL stall_first_gnt: got %b want 1", bus.gnt0);
    end
    tick();
    bus.req0  = 1'b0;
    bus.mode1 = 1'b0;
    bus.pix1  = '1;
    bus.coef1 = '1;
    for (int c = 1; c <= 6; c++) begin
      bus.stall = (c <= 2);
      bus.req1  = (c <= 2);
      #1;
      if (c <= 2) begin
        n_cmp++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
          n_err++;
          $display("FAIL stall_no_gnt[%0d]: got %b want 00", c, {bus.gnt0, bus.gnt1});
        end
      end
      if (bus.rsp_valid === 1'b1) pulses++;
      if (c == 5) begin
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q} !== {1'b1, 1'b0, 20'd45000, 8'd19}) begin
          n_err++;
          $display("FAIL stall_rsp: got v=%b id=%b raw=%0d q=%0d want v=1 id=0 raw=45000 q=19",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q);
        end
      end
      tick();
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL stall_pulses: got %0d want 1", pulses);
    end
  endtask

  // Four jobs from requester 0 on consecutive cycles, straddling both
  // quantizer thresholds.
  task automatic test_back_to_back;
    logic [71:0] bp [4];
    logic [71:0] bc [4];
    logic        bm [4];
    logic [19:0] er [4];
    logic [7:0]  eq [4];
    bp[0] = {56'd0, 8'd254, 8'd255};        bc[0] = {56'd0, 8'd1, 8'd8};
    bm[0] = 1'b0; er[0] = 20'd2294; eq[0] = 8'd0;
    bp[1] = {56'd0, 8'd255, 8'd255};        bc[1] = {56'd0, 8'd1, 8'd8};
    bm[1] = 1'b0; er[1] = 20'd2295; eq[1] = 8'd1;
    bp[2] = {{7{8'hFF}}, 8'd254, 8'd255};   bc[2] = {{7{8'hFF}}, 8'd1, 8'd1};
    bm[2] = 1'b1; er[2] = 20'd509;  eq[2] = 8'd0;
    bp[3] = {{7{8'hFF}}, 8'd255, 8'd255};   bc[3] = {{7{8'hFF}}, 8'd1, 8'd1};
    bm[3] = 1'b1; er[3] = 20'd510;  eq[3] = 8'd1;
    for (int i = 0; i < 8; i++) begin
      bus.req0 = (i < 4);
      if (i < 4) begin
        bus.pix0  = bp[i];
        bus.coef0 = bc[i];
        bus.mode0 = bm[i];
      end
      #1;
      n_cmp++;
      if (bus.gnt0 !== (i < 4)) begin
        n_err++;
        $display("FAIL b2b_gnt[%0d]: got %b want %b", i, bus.gnt0, (i < 4));
      end
      if (i >= 3 && i <= 6) begin
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q} !== {1'b1, 1'b0, er[i-3], eq[i-3]}) begin
          n_err++;
          $display("FAIL b2b_rsp[%0d]: got v=%b id=%b raw=%0d q=%0d want v=1 id=0 raw=%0d q=%0d",
                   i - 3, bus.rsp_valid, bus.rsp_id, bus.rsp_raw, bus.rsp_q, er[i-3], eq[i-3]);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
          n_err++;
          $display("FAIL b2b_drain: got v=%b busy=%b want 00", bus.rsp_valid, bus.busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    bus.req0  = 1'b1;
    bus.mode0 = 1'b0;
    bus.pix0  = '1;
    bus.coef0 = '1;
    #1;
    n_cmp++;
    if (bus.gnt0 !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_gnt: got %b want 1", bus.gnt0);
    end
    tick();
    bus.req0 = 1'b0;
    rst_n    = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.rsp_valid, bus.gnt0, bus.gnt1} !== 4'b0000) begin
      n_err++;
      $display("FAIL rmid_async: got %b want 0000", {bus.busy, bus.rsp_valid, bus.gnt0, bus.gnt1});
    end
    tick();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
        n_err++;
        $display("FAIL rmid_ghost[%0d]: got v=%b busy=%b want 00", c, bus.rsp_valid, bus.busy);
      end
      tick();
    end
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_err++;
      $display("FAIL rmid_tie: got %b want 10", {bus.gnt0, bus.gnt1});
    end
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_conv_single();
    test_fc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
